// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO slice.
package fifo_pkg;
  localparam int DSIZE_DEF = 8;
  localparam int ASIZE_DEF = 3;
endpackage

// File: rtl/sync_fifo_if.sv
// Write/read handshake bundle between a FIFO user (master) and the FIFO (slave).
interface sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
);
  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             wfull;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;

  modport master (output wdata, winc, rinc, input  wfull, rdata, rempty);
  modport slave  (input  wdata, winc, rinc, output wfull, rdata, rempty);
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DSIZE register array: synchronous write, asynchronous read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);
  localparam int DEPTH = 1 << ASIZE;

  logic [DEPTH-1:0][DSIZE-1:0] mem;

  // Storage is intentionally not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  sync_fifo_if.slave  fif
);
  logic [ASIZE:0] wptr, rptr;
  logic           wen, ren;

  // Requests are qualified by the current flags only; a pop does not open
  // room for a same-cycle push when full.
  assign wen = fif.winc & ~fif.wfull;
  assign ren = fif.rinc & ~fif.rempty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wen) wptr <= wptr + (ASIZE+1)'(1);
      if (ren) rptr <= rptr + (ASIZE+1)'(1);
    end
  end

  assign fif.rempty = (wptr == rptr);
  assign fif.wfull  = (wptr[ASIZE] != rptr[ASIZE]) &&
                      (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);

  fifo_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_mem (
    .clk   (clk),
    .we    (wen),
    .waddr (wptr[ASIZE-1:0]),
    .wdata (fif.wdata),
    .raddr (rptr[ASIZE-1:0]),
    .rdata (fif.rdata)
  );
endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DSIZE=8, ASIZE=3).
module tb_sync_fifo;
  import fifo_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  sync_fifo_if #(.DSIZE(8)) fif ();

  sync_fifo #(.DSIZE(8), .ASIZE(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fif   (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before checking/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    fif.winc  = 1'b0;
    fif.rinc  = 1'b0;
    fif.wdata = 8'h00;
    #1;
    chk("rst_empty_t0", 32'(fif.rempty), 32'd1);
    chk("rst_full_t0",  32'(fif.wfull),  32'd0);
    repeat (4) step();
    chk("rst_empty_held", 32'(fif.rempty), 32'd1);
    chk("rst_full_held",  32'(fif.wfull),  32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_empty_rel", 32'(fif.rempty), 32'd1);
    chk("rst_full_rel",  32'(fif.wfull),  32'd0);

    // Streaming: each word written, seen on rdata, popped the next edge.
    fif.rinc = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fif.winc  = 1'b1;
      fif.wdata = 8'(8'h30 + i);
      step();
      fif.winc = 1'b0;
      chk("stream_nempty", 32'(fif.rempty), 32'd0);
      chk("stream_data",   32'(fif.rdata),  32'(8'h30 + i));
      chk("stream_nfull",  32'(fif.wfull),  32'd0);
      step();
      chk("stream_popped", 32'(fif.rempty), 32'd1);
    end

    // Fill past capacity (pointers wrap through the MSB here).
    fif.rinc = 1'b0;
    for (int i = 0; i < 11; i++) begin
      fif.winc  = 1'b1;
      fif.wdata = 8'(8'h10 + i);
      step();
      chk("fill_full", 32'(fif.wfull), (i >= 7) ? 32'd1 : 32'd0);
    end
    fif.winc = 1'b0;
    chk("fill_head", 32'(fif.rdata), 32'h10);

    // Drain past empty; writes 0x18..0x1A must not appear.
    fif.rinc = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) chk("drain_data", 32'(fif.rdata), 32'(8'h10 + i));
      step();
      chk("drain_empty", 32'(fif.rempty), (i >= 7) ? 32'd1 : 32'd0);
      chk("drain_nfull", 32'(fif.wfull),  32'd0);
    end
    fif.rinc = 1'b0;

    // Simultaneous push/pop when empty: write wins, read ignored.
    fif.winc  = 1'b1;
    fif.rinc  = 1'b1;
    fif.wdata = 8'h5A;
    step();
    chk("sim_empty_nempty", 32'(fif.rempty), 32'd0);
    chk("sim_empty_data",   32'(fif.rdata),  32'h5A);
    fif.winc = 1'b0;
    step();
    chk("sim_empty_popped", 32'(fif.rempty), 32'd1);
    fif.rinc = 1'b0;

    // Refill, then push+pop at full: pop accepted, push dropped.
    for (int i = 0; i < 8; i++) begin
      fif.winc  = 1'b1;
      fif.wdata = 8'(8'h40 + i);
      step();
    end
    chk("refill_full", 32'(fif.wfull), 32'd1);
    fif.winc  = 1'b1;
    fif.rinc  = 1'b1;
    fif.wdata = 8'hEE;
    step();
    fif.winc = 1'b0;
    chk("sim_full_nfull", 32'(fif.wfull), 32'd0);
    for (int i = 0; i < 7; i++) begin
      chk("sim_full_data", 32'(fif.rdata), 32'(8'h41 + i));
      chk("sim_full_nempty", 32'(fif.rempty), 32'd0);
      step();
    end
    chk("sim_full_occ7", 32'(fif.rempty), 32'd1);
    fif.rinc = 1'b0;

    // Concurrent push/pop at mid occupancy keeps the count.
    fif.winc = 1'b1;
    fif.wdata = 8'h71;
    step();
    fif.wdata = 8'h72;
    fif.rinc  = 1'b1;
    step();
    fif.winc = 1'b0;
    chk("mid_rw_data", 32'(fif.rdata), 32'h72);
    step();
    chk("mid_rw_empty", 32'(fif.rempty), 32'd1);
    fif.rinc = 1'b0;

    // Mid-operation reset discards stored words asynchronously.
    for (int i = 0; i < 3; i++) begin
      fif.winc  = 1'b1;
      fif.wdata = 8'(8'h61 + i);
      step();
    end
    fif.winc = 1'b0;
    chk("pre_rst_nempty", 32'(fif.rempty), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_empty", 32'(fif.rempty), 32'd1);
    chk("async_rst_nfull", 32'(fif.wfull),  32'd0);
    step();
    rst_n = 1'b1;
    fif.winc  = 1'b1;
    fif.wdata = 8'hAA;
    step();
    fif.winc = 1'b0;
    chk("post_rst_data",   32'(fif.rdata),  32'hAA);
    chk("post_rst_nempty", 32'(fif.rempty), 32'd0);
    fif.rinc = 1'b1;
    step();
    fif.rinc = 1'b0;
    chk("post_rst_empty", 32'(fif.rempty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DSIZE, default 8, data word width in bits.
REQ-002 Parameter ASIZE, default 3, address width; DEPTH = 2**ASIZE entries (default 8).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 wdata  input  DSIZE  write data.
REQ-007 winc  input  1  write request.
REQ-008 wfull  output  1  FIFO holds DEPTH entries.
REQ-009 rinc  input  1  read request (pop).
REQ-010 rdata  output  DSIZE  head-of-FIFO data.
REQ-011 rempty  output  1  FIFO holds zero entries.

Function
REQ-012 Write pointer and read pointer SHALL each be ASIZE+1 bits: low ASIZE bits address memory, MSB is the wrap bit.
REQ-013 A write SHALL occur on a rising clk edge iff winc=1 and wfull=0: mem[wptr] <= wdata, wptr <= wptr+1.
REQ-014 A read SHALL occur on a rising clk edge iff rinc=1 and rempty=0: rptr <= rptr+1.
REQ-015 Writes while wfull=1 SHALL be dropped with no state change; reads while rempty=1 SHALL be ignored with no state change.
REQ-016 rdata SHALL be combinational from mem[rptr low bits] (first-word fall-through): the head word is valid whenever rempty=0, with zero-cycle read latency.
REQ-017 rdata is don't-care while rempty=1.
REQ-018 rempty SHALL be 1 iff wptr == rptr (all ASIZE+1 bits).
REQ-019 wfull SHALL be 1 iff the pointer MSBs differ and the low ASIZE bits are equal.
REQ-020 Flags SHALL be derived from registered pointers, so they update in the same cycle as the pointer change, with no extra latency: after the DEPTH-th accepted write, wfull=1 in the next cycle.
REQ-021 Simultaneous accepted read and write SHALL leave occupancy unchanged.
REQ-022 Simultaneous request when full: the read is accepted and the write is dropped. The write is qualified by the current wfull, so the write is not accepted even though the read frees a slot.
REQ-023 Simultaneous request when empty: the write is accepted and the read is ignored. The new word appears on rdata the next cycle.
REQ-024 Pointers SHALL wrap modulo 2**(ASIZE+1) with no special handling.
REQ-025 Data SHALL emerge in exact write order, with no loss or duplication across any number of wraps.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear wptr and rptr to 0, forcing rempty=1 and wfull=0 immediately.
REQ-027 Memory contents SHALL NOT be reset.
REQ-028 Reset asserted mid-operation SHALL discard all stored entries.
REQ-029 The first accepted write after rst_n deasserts lands at address 0.

Structure
REQ-030 A shared package fifo_pkg SHALL hold the default DSIZE/ASIZE constants.
REQ-031 Storage SHALL be one sub-module, fifo_mem: a DEPTH x DSIZE register array with a synchronous write port and an asynchronous read port.
REQ-032 Pointer and flag logic SHALL reside in sync_fifo.

Verification
REQ-033 Reset: hold rst_n=0 for 4 cycles -> rempty=1 and wfull=0 during reset and after release.
REQ-034 Streaming: rinc=1 held, 10 writes of distinct values on alternate cycles -> each value appears on rdata in order and is consumed; rempty=1 at the end; wfull never asserts.
REQ-035 Fill: rinc=0, winc=1 for 11 cycles with values 0x10..0x1A -> wfull=1 after the 8th write; 0x18..0x1A are dropped; rdata=0x10.
REQ-036 Drain: winc=0, rinc=1 for 11 cycles from full -> rdata sequence is 0x10..0x17; rempty=1 after the 8th pop; the extra 3 reads cause no pointer change.
REQ-037 Simultaneous at full: winc=rinc=1 with FIFO full -> occupancy becomes 7; wfull=0 next cycle; the written value is dropped.
REQ-038 Mid-operation reset: write 3 words, assert rst_n=0 -> rempty=1 immediately; the next write of 0xAA is read back first as 0xAA.
